// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the programmable-threshold sync FIFO.
// Pointer wrap is explicit so DEPTH need not be a power of two.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Write/read handshake, thresholds and status bundle of sync_fifo_prog.
// master drives requests and thresholds; slave is the FIFO.
interface sync_fifo_prog_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    localparam int CNT_WIDTH = cnt_width(DEPTH);

    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [CNT_WIDTH-1:0]  af_thresh;
    logic [CNT_WIDTH-1:0]  ae_thresh;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic [CNT_WIDTH-1:0]  count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_en, read_en, data_in, af_thresh, ae_thresh,
        input  data_out, data_valid, count, full, empty,
        input  almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  write_en, read_en, data_in, af_thresh, ae_thresh,
        output data_out, data_valid, count, full, empty,
        output almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one async read.
// Contents are deliberately not reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost flags and occupancy count.
// Define FIFO_FWFT_EN for first-word fall-through; default is a registered read.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input logic             clk,
    input logic             reset_n,
    sync_fifo_prog_if.slave bus
);

    localparam int CNT_WIDTH = cnt_width(DEPTH);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    // A full FIFO still takes a write when a read frees the slot this edge.
    assign wr_acc = bus.write_en && (!full_q || bus.read_en);
    assign rd_acc = bus.read_en && !empty_q;

    always_comb begin
        count_nxt = count_q;
        unique case (1'b1)
            wr_acc && !rd_acc: count_nxt = count_q + 1'b1;
            rd_acc && !wr_acc: count_nxt = count_q - 1'b1;
            default:           count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= PTR_WIDTH'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
            end
            if (rd_acc) begin
                rd_ptr <= PTR_WIDTH'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == FULL_CNT);
            empty_q  <= (count_nxt == '0);
            afull_q  <= (bus.af_thresh != '0) && (count_nxt >= bus.af_thresh);
            aempty_q <= (count_nxt <= bus.ae_thresh);
            ovf_q    <= bus.write_en && !wr_acc;
            unf_q    <= bus.read_en && !rd_acc;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(bus.data_in),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign bus.data_out   = empty_q ? '0 : rd_data;
    assign bus.data_valid = !empty_q;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dvalid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= rd_acc;
            if (rd_acc) begin
                dout_q <= rd_data;
            end
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = dvalid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: DEPTH=8 and DEPTH=5 instances.
// Works in both the default and FIFO_FWFT_EN builds.
module tb_sync_fifo_prog;

    logic clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_a[$];
    logic [15:0] sb_b[$];
    int cnt_a = 0;
    int cnt_b = 0;
    int max_b = 0;

    sync_fifo_prog_if #(.DATA_WIDTH(16), .DEPTH(8)) ifa ();
    sync_fifo_prog_if #(.DATA_WIDTH(16), .DEPTH(5)) ifb ();

    sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(8)) dut_a (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (ifa)
    );

    sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(5)) dut_b (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_a(input logic we, input logic re, input logic [15:0] din);
        logic wacc, racc;
        logic [15:0] exp;
        logic [3:0] ef, af;
        wacc = we && (cnt_a != 8 || re);
        racc = re && (cnt_a != 0);
        exp = '0;
`ifdef FIFO_FWFT_EN
        exp = (cnt_a != 0) ? sb_a[0] : 16'h0;
        checks++;
        if (ifa.data_valid !== (cnt_a != 0) || (cnt_a != 0 && ifa.data_out !== exp)) begin
            errors++;
            $display("FAIL head_a dv=%0b data=%h want dv=%0b data=%h",
                     ifa.data_valid, ifa.data_out, cnt_a != 0, exp);
        end
`endif
        ifa.write_en = we;
        ifa.read_en  = re;
        ifa.data_in  = din;
        @(posedge clk);
        #1;
        ifa.write_en = 1'b0;
        ifa.read_en  = 1'b0;
        if (racc) exp = sb_a.pop_front();
`ifndef FIFO_FWFT_EN
        checks++;
        if (ifa.data_valid !== racc || (racc && ifa.data_out !== exp)) begin
            errors++;
            $display("FAIL read_a dv=%0b data=%h want dv=%0b data=%h",
                     ifa.data_valid, ifa.data_out, racc, exp);
        end
`endif
        if (wacc) sb_a.push_back(din);
        cnt_a = cnt_a + (wacc ? 1 : 0) - (racc ? 1 : 0);
        checks++;
        if (ifa.count !== 4'(cnt_a)) begin
            errors++;
            $display("FAIL count_a got %0d want %0d", ifa.count, cnt_a);
        end
        checks++;
        if (ifa.overflow !== (we && !wacc) || ifa.underflow !== (re && !racc)) begin
            errors++;
            $display("FAIL err_a ov=%0b un=%0b want ov=%0b un=%0b",
                     ifa.overflow, ifa.underflow, we && !wacc, re && !racc);
        end
        ef = {cnt_a == 8, cnt_a == 0,
              ifa.af_thresh != 0 && cnt_a >= int'(ifa.af_thresh),
              cnt_a <= int'(ifa.ae_thresh)};
        af = {ifa.full, ifa.empty, ifa.almost_full, ifa.almost_empty};
        checks++;
        if (af !== ef) begin
            errors++;
            $display("FAIL flags_a got %b want %b (full,empty,af,ae)", af, ef);
        end
    endtask

    task automatic drive_b(input logic we, input logic re, input logic [15:0] din);
        logic wacc, racc;
        logic [15:0] exp;
        wacc = we && (cnt_b != 5 || re);
        racc = re && (cnt_b != 0);
        exp = '0;
`ifdef FIFO_FWFT_EN
        exp = (cnt_b != 0) ? sb_b[0] : 16'h0;
        checks++;
        if (ifb.data_valid !== (cnt_b != 0) || (cnt_b != 0 && ifb.data_out !== exp)) begin
            errors++;
            $display("FAIL head_b dv=%0b data=%h want dv=%0b data=%h",
                     ifb.data_valid, ifb.data_out, cnt_b != 0, exp);
        end
`endif
        ifb.write_en = we;
        ifb.read_en  = re;
        ifb.data_in  = din;
        @(posedge clk);
        #1;
        ifb.write_en = 1'b0;
        ifb.read_en  = 1'b0;
        if (racc) exp = sb_b.pop_front();
`ifndef FIFO_FWFT_EN
        checks++;
        if (ifb.data_valid !== racc || (racc && ifb.data_out !== exp)) begin
            errors++;
            $display("FAIL read_b dv=%0b data=%h want dv=%0b data=%h",
                     ifb.data_valid, ifb.data_out, racc, exp);
        end
`endif
        if (wacc) sb_b.push_back(din);
        cnt_b = cnt_b + (wacc ? 1 : 0) - (racc ? 1 : 0);
        if (int'(ifb.count) > max_b) max_b = int'(ifb.count);
        checks++;
        if (ifb.count !== 3'(cnt_b) || ifb.full !== (cnt_b == 5) || ifb.empty !== (cnt_b == 0)) begin
            errors++;
            $display("FAIL state_b count=%0d full=%0b empty=%0b want %0d %0b %0b",
                     ifb.count, ifb.full, ifb.empty, cnt_b, cnt_b == 5, cnt_b == 0);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ifa.write_en = 0; ifa.read_en = 0; ifa.data_in = '0;
        ifb.write_en = 0; ifb.read_en = 0; ifb.data_in = '0;
        ifa.af_thresh = 4'd6; ifa.ae_thresh = 4'd2;
        ifb.af_thresh = 3'd4; ifb.ae_thresh = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifa.count !== 4'd0 || ifa.data_valid !== 1'b0 || ifa.data_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_a count=%0d dv=%0b data=%h want 0 0 0000",
                     ifa.count, ifa.data_valid, ifa.data_out);
        end
        checks++;
        if ({ifa.full, ifa.empty, ifa.almost_full, ifa.almost_empty,
             ifa.overflow, ifa.underflow} !== 6'b010100) begin
            errors++;
            $display("FAIL reset_flags_a got %b want 010100",
                     {ifa.full, ifa.empty, ifa.almost_full, ifa.almost_empty,
                      ifa.overflow, ifa.underflow});
        end
        checks++;
        if (ifb.count !== 3'd0 || ifb.empty !== 1'b1 || ifb.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_b count=%0d empty=%0b dv=%0b want 0 1 0",
                     ifb.count, ifb.empty, ifb.data_valid);
        end
        reset_n = 1'b1;
        sb_a.delete(); sb_b.delete();
        cnt_a = 0; cnt_b = 0;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) drive_a(1'b1, 1'b0, 16'(i));
        for (int i = 1; i <= 8; i++) drive_a(1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_underflow();
        drive_a(1'b0, 1'b1, 16'h0);
        drive_a(1'b0, 1'b0, 16'h0);
        drive_a(1'b1, 1'b1, 16'h5555);
        drive_a(1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_overflow_full_rw();
        for (int i = 0; i < 8; i++) drive_a(1'b1, 1'b0, 16'h0100 + 16'(i));
        drive_a(1'b1, 1'b0, 16'hdead);
        drive_a(1'b0, 1'b0, 16'h0);
        ifa.af_thresh = 4'd0;
        drive_a(1'b0, 1'b0, 16'h0);
        ifa.af_thresh = 4'd6;
        drive_a(1'b1, 1'b1, 16'haaaa);
        for (int i = 0; i < 8; i++) drive_a(1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_back_to_back();
        drive_a(1'b1, 1'b0, 16'h7000);
        for (int i = 1; i <= 10; i++) drive_a(1'b1, 1'b1, 16'h7000 + 16'(i));
        drive_a(1'b0, 1'b1, 16'h0);
        drive_a(1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) drive_b(1'b1, 1'b0, 16'h0b00 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            drive_b(1'b1, 1'b0, 16'h0c00 + 16'(i));
            drive_b(1'b0, 1'b1, 16'h0);
        end
        drive_b(1'b1, 1'b0, 16'h0d00);
        drive_b(1'b1, 1'b0, 16'h0d01);
        drive_b(1'b1, 1'b0, 16'h0d02);
        for (int i = 0; i < 6; i++) drive_b(1'b1, 1'b1, 16'h0e00 + 16'(i));
        for (int i = 0; i < 6; i++) drive_b(1'b0, 1'b1, 16'h0);
        checks++;
        if (max_b > 5 || max_b < 5) begin
            errors++;
            $display("FAIL wrap_max_count got %0d want 5", max_b);
        end
    endtask

    task automatic test_fwft();
        drive_a(1'b1, 1'b0, 16'h1234);
        checks++;
`ifdef FIFO_FWFT_EN
        if (ifa.data_valid !== 1'b1 || ifa.data_out !== 16'h1234) begin
            errors++;
            $display("FAIL fwft_first dv=%0b data=%h want 1 1234",
                     ifa.data_valid, ifa.data_out);
        end
`else
        if (ifa.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL std_no_fallthrough dv=%0b want 0", ifa.data_valid);
        end
`endif
        drive_a(1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive_a(1'b1, 1'b0, 16'h4400 + 16'(i));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if (ifa.count !== 4'd0 || ifa.empty !== 1'b1 || ifa.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid count=%0d empty=%0b dv=%0b want 0 1 0",
                     ifa.count, ifa.empty, ifa.data_valid);
        end
        sb_a.delete();
        cnt_a = 0;
        drive_a(1'b0, 1'b1, 16'h0);
        drive_a(1'b1, 1'b0, 16'h9999);
        drive_a(1'b0, 1'b1, 16'h0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_overflow_full_rw();
        test_back_to_back();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised single-clock FIFO with a programmable almost-full/almost-empty threshold, occupancy count, a data-valid qualifier and optional first-word fall-through. DEPTH need not be a power of two. It is the general-purpose buffer for new datapaths and keeps the existing FIFO control and flag signal set.

## Interface
- DATA_WIDTH, 16, width of each entry
- DEPTH, 8, number of entries; any value ≥ 2
- CNT_WIDTH, localparam $clog2(DEPTH+1), width of count and thresholds
- clk  in  1  sole clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- write_en  in  1  write request
- read_en  in  1  read request (read acknowledge in FWFT mode)
- data_in  in  DATA_WIDTH  write data
- af_thresh  in  CNT_WIDTH  almost-full threshold; 0 disables almost_full
- ae_thresh  in  CNT_WIDTH  almost-empty threshold
- data_out  out  DATA_WIDTH  read data
- data_valid  out  1  data_out qualifier
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1  status flags
- overflow, underflow  out  1  one-cycle error pulses

## Operation
- wr_acc = write_en && (!full || read_en). A write to a full FIFO is accepted only with a simultaneous read.
- rd_acc = read_en && !empty. There is no bypass at empty.
- Simultaneous reads and writes:
  - Full: both requests are accepted and count is unchanged.
  - Empty: the write is accepted, the read is rejected, and underflow pulses.
- Count update: count+1 on write only, count-1 on read only, otherwise unchanged.
- wr_ptr and rd_ptr advance on their accept. Each wraps from DEPTH-1 to 0 explicitly, with no power-of-two masking.
- Flags are registered and reflect the post-edge count:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (af_thresh!=0 && count>=af_thresh)
  - almost_empty = (count<=ae_thresh)
- overflow is 1 the cycle after write_en is rejected. underflow is 1 the cycle after read_en is rejected. Both are otherwise 0.
- Threshold changes take effect at the next edge.
- Reset (reset_n=0 at an edge):
  - wr_ptr, rd_ptr, count, data_out, data_valid, full, almost_full, overflow and underflow go to 0.
  - empty and almost_empty go to 1.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries. The first cycle after reset behaves as an empty FIFO.

## Timing
- Standard mode:
  - data_out is registered and loads mem[rd_ptr] on rd_acc, with latency 1.
  - data_valid is high exactly the cycle after rd_acc.
  - data_out holds its value otherwise.
- FWFT mode:
  - data_out = mem[rd_ptr] whenever !empty, and data_valid = !empty.
  - A word written into an empty FIFO appears on data_out one cycle after the write edge.
  - An accepted read presents the next word in the following cycle.
- Sustained throughput is one write and one read per cycle.

## Configuration
- FIFO_FWFT_EN:
  - Defined: first-word fall-through behaviour as in Timing.
  - Undefined: standard registered read with latency 1.
- All flag, count and error behaviour is identical in both modes.

## Structure
- Package sync_fifo_pkg holds:
  - the cnt_width(depth) function
  - the pointer-increment-with-wrap function
  - the default DATA_WIDTH/DEPTH constants
- Sub-module sync_fifo_mem is a DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port. The top level holds pointers, count, flags and output logic.

## Test plan
- Standard build, DEPTH=8, af=6, ae=2: write 8 words 0x0001..0x0008 -> full=1 after the 8th edge and almost_full from count=6. Read 8 -> data_out 0x0001..0x0008, each with data_valid the cycle after its read. empty=1 at the end.
- Read when empty -> underflow pulses 1 cycle, count stays 0, data_valid=0.
- At full, a 9th write alone -> overflow pulse, count=8. Write 0xAAAA with a simultaneous read -> count=8, and the last word read out is 0xAAAA.
- DEPTH=5 (non-power-of-two): 20 interleaved write/read pairs -> data in order across pointer wrap, count never exceeds 5.
- FIFO_FWFT_EN, write 0x1234 into empty -> data_out=0x1234 with data_valid=1 on the next cycle, before any read_en.
- Assert reset_n=0 at count=4 -> at the next edge count=0, empty=1, data_valid=0. A subsequent read -> underflow.
